// File: rtl/keypad_bcd_entry_pkg.sv
// Shared types and key decode for the keypad entry path.
// Maps (row, col) matrix positions to 4-bit key codes.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [3:0] KEY_STAR   = 4'hE;
  localparam logic [3:0] KEY_CLR    = 4'hC;
  localparam int         MAX_DIGITS = 8;

  // row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: * 0 # D
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_bcd_entry_tick.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, first tick SCAN_DIV-1 clocks after reset.
// No backpressure; the strobe is unconditional.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner/debouncer feeding a packed-BCD entry register; key_valid one clk after the confirming tick.
// No backpressure: each confirmed press is acted on immediately, held keys never repeat.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [31:0] data_BCD,
  output logic [3:0]  digit_count,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        overflow
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TICKS);

  logic [3:0]    row_meta, row_sync;
  logic          tick;
  state_t        state;
  logic [1:0]    col_idx, row_lat, first_low;
  logic [CW-1:0] deb_cnt, cnt_nxt;
  logic          any_low, deb_hit;
  logic [3:0]    code;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_sync[i]) first_low = 2'(i);
  end

  assign any_low = ~&row_sync;
  assign cnt_nxt = deb_cnt + 1'b1;
  assign deb_hit = (cnt_nxt == DEB_LAST);
  assign code    = keymap(row_lat, col_idx);
  assign col_n   = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      row_lat     <= 2'd0;
      deb_cnt     <= '0;
      data_BCD    <= 32'h0;
      digit_count <= 4'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      overflow    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      overflow  <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (!any_low) begin
              col_idx <= col_idx + 1'b1;
            end else begin
              row_lat <= first_low;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            // A lower row appearing counts as instability and restarts the scan.
            if (any_low && first_low == row_lat) begin
              if (deb_hit) begin
                state     <= HELD;
                deb_cnt   <= '0;
                key_valid <= 1'b1;
                key_code  <= code;
                if (code <= 4'd9) begin
                  if (digit_count < 4'(MAX_DIGITS)) begin
                    data_BCD    <= {data_BCD[27:0], code};
                    digit_count <= digit_count + 1'b1;
                  end else begin
                    overflow <= 1'b1;
                  end
                end else if (code == KEY_STAR) begin
                  if (digit_count != 4'd0) begin
                    data_BCD    <= {4'h0, data_BCD[31:4]};
                    digit_count <= digit_count - 1'b1;
                  end
                end else if (code == KEY_CLR) begin
                  data_BCD    <= 32'h0;
                  digit_count <= 4'd0;
                end
              end else begin
                deb_cnt <= cnt_nxt;
              end
            end else begin
              state   <= SCAN;
              deb_cnt <= '0;
            end
          end
          HELD: begin
            if (any_low) begin
              deb_cnt <= '0;
            end else if (deb_hit) begin
              state   <= SCAN;
              deb_cnt <= '0;
              col_idx <= col_idx + 1'b1;
            end else begin
              deb_cnt <= cnt_nxt;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_bcd_entry.md
Name: keypad_bcd_entry

Overview:
- Scans a 4x4 active-low key matrix, debounces it and decodes each confirmed press to a 4-bit key code.
- Assembles up to eight decimal digits into a 32-bit packed-BCD word in the same format the 7-segment display driver consumes (digit 0 in bits [3:0]).
- This block is the input end of the multiplexed-display path: it sits between the keypad pins and the display driver's data_BCD input.

Parameters:
- SCAN_DIV, 100000: clk cycles per scan tick (1 kHz at 100 MHz); minimum legal value 4.
- DEBOUNCE_TICKS, 20: consecutive stable ticks needed to confirm a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_n  input  4  matrix rows, active-low, externally pulled up, asynchronous to clk.
- col_n  output  4  column drive, one-hot active-low.
- data_BCD  output  32  entered digits, packed BCD, newest digit in [3:0].
- digit_count  output  4  number of valid digits, 0..8.
- key_valid  output  1  one-clk pulse per confirmed press.
- key_code  output  4  code of the last confirmed key; holds its value between presses.
- overflow  output  1  one-clk pulse when a digit is pressed with digit_count==8.

Behaviour:
- Reset (asynchronous, rst_n low):
  - col_n=4'b1110; data_BCD=0; digit_count=0; key_valid=0; key_code=0; overflow=0.
  - State=SCAN, divider=0, debounce counter=0.
  - Reset mid-operation aborts everything; no pulse is emitted.
- row_n passes through a 2-flop synchronizer. Row decisions use only the synchronized value, sampled on the scan-tick cycle.
- Scan tick: single-cycle strobe every SCAN_DIV clks from a free-running divider.
- Key map (row r, col c), row0/col0 first:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
  - Codes: digits = their value, A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
- States:
  - SCAN: on a tick, if all synchronized rows are high, rotate the column (col_n 1110 -> 1101 -> 1011 -> 0111 -> 1110). If any row is low, latch the current column and the lowest-index low row, clear the counter, go to DEBOUNCE. The column is not rotated.
  - DEBOUNCE: column held. On each tick:
    - If the latched row is low and no lower-index row is low, increment the counter.
    - Otherwise return to SCAN with the counter cleared, and rotate the column on the next tick.
    - When the counter reaches DEBOUNCE_TICKS, go to HELD and, in the next clk cycle, assert key_valid, update key_code and apply the action.
  - HELD: column held, no further pulses (no auto-repeat). On each tick:
    - If all rows are high, increment the counter.
    - If any row is low, clear the counter.
    - At DEBOUNCE_TICKS, go to SCAN and rotate the column.
- Actions, applied in the same cycle as key_valid:
  - Digit 0-9: if digit_count<8, data_BCD <= {data_BCD[27:0], d} and digit_count+1. Otherwise overflow=1 and there is no change.
  - * (backspace): if digit_count>0, data_BCD <= {4'h0, data_BCD[31:4]} and digit_count-1. Otherwise no-op.
  - C (clear): data_BCD=0, digit_count=0.
  - A, B, D, #: reported through key_code only; data is unchanged.
- Simultaneous keys:
  - Keys in other columns are invisible while a column is held.
  - Within one column, the lowest row wins.
  - A press of a lower row during DEBOUNCE restarts the scan.
- Latency: the first low sample to key_valid takes DEBOUNCE_TICKS ticks plus 1 clk.

Decomposition:
- Package keypad_pkg:
  - State enum SCAN/DEBOUNCE/HELD.
  - Key code constants KEY_STAR=4'hE, KEY_CLR=4'hC.
  - Function keymap(row, col) -> code.
  - Constant MAX_DIGITS=8.
- Sub-module scan_tick_gen (parameter SCAN_DIV; ports clk, rst_n, tick): the divider.
- Synchronizer, FSM and the entry register live in the top-level block.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3):
- Reset with rows high -> col_n=1110 and all outputs 0. Over 16 clks col_n cycles 1110, 1101, 1011, 0111, 1110 at 4-clk spacing.
- Hold '5' (row1, col1) 40 ticks -> exactly one key_valid, key_code=5, data_BCD=0x00000005, digit_count=1. Release, then press '7' -> data_BCD=0x00000057, digit_count=2.
- Pulse row1 low for 2 ticks while col1 is active -> no key_valid, state returns to SCAN, scanning resumes.
- Enter 1,2,...,9 -> data_BCD=0x12345678, digit_count=8. The ninth press gives overflow=1 for 1 clk with key_valid=1, key_code=9, data unchanged.
- From 0x00000057: * -> 0x00000005 (count 1); * -> 0 (count 0); * -> no change. Then enter 3 and press C -> 0, count 0.
- Hold '4' and '7' together (rows 1 and 2, col0) -> key_code=4 only. Separately, assert rst_n low mid-DEBOUNCE -> no key_valid, all outputs reset, col_n=1110.
